// File: rtl/chan_eth_frame_builder_if.sv
// ---------------------------------------------------------------------------
// chan_eth_frame_builder_if
// Byte-wide AXI-stream link from the frame builder to the Ethernet MAC
// transmit FIFO.
//   tx_axis_fifo_tdata   frame byte
//   tx_axis_fifo_tvalid  byte valid
//   tx_axis_fifo_tready  MAC FIFO can accept a byte
//   tx_axis_fifo_tlast   last byte of the frame
// master: the frame builder (drives data/valid/last, samples ready)
// slave : the MAC FIFO side (samples data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface chan_eth_frame_builder_if;
  logic [7:0] tx_axis_fifo_tdata;
  logic       tx_axis_fifo_tvalid;
  logic       tx_axis_fifo_tready;
  logic       tx_axis_fifo_tlast;

  modport master (
    output tx_axis_fifo_tdata,
    output tx_axis_fifo_tvalid,
    output tx_axis_fifo_tlast,
    input  tx_axis_fifo_tready
  );

  modport slave (
    input  tx_axis_fifo_tdata,
    input  tx_axis_fifo_tvalid,
    input  tx_axis_fifo_tlast,
    output tx_axis_fifo_tready
  );
endinterface

// File: rtl/chan_eth_frame_builder.sv
// ---------------------------------------------------------------------------
// chan_eth_frame_builder
// Packetiser between one TDS channel FIFO (FWFT, DATA_WIDTH-bit words) and
// the byte-wide MAC transmit FIFO. Each batch of up to MAX_WORDS channel
// words becomes one Ethernet frame: 18 header bytes (dst MAC, src MAC,
// ethertype, channel id, word count, 16-bit sequence number LSB first),
// then DATA_WIDTH/8 payload bytes per word, MSB first.
// Ports:
//   clk, reset              MAC clock, asynchronous active-high reset
//   enable                  allows new frames to start
//   D_MAC_add, S_MAC_add    destination / source MAC, latched at frame start
//   counter_th              fill level that starts a frame (0 acts as 1)
//   idle_counter_number_th  idle-timeout cycles (0 disables)
//   channel_data/_counter/_fifo_empty, channel_data_read  channel FIFO side
//   tx_axis                 byte stream to the MAC FIFO (interface, master)
//   busy                    high from frame start until the tlast handshake
//   frame_count             completed frames, wrapping
// ---------------------------------------------------------------------------
module chan_eth_frame_builder #(
  parameter int          DATA_WIDTH  = 120,
  parameter int          COUNT_WIDTH = 10,
  parameter int          MAX_WORDS   = 96,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter logic [7:0]  CHANNEL_ID  = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [47:0]            D_MAC_add,
  input  logic [47:0]            S_MAC_add,
  input  logic [11:0]            counter_th,
  input  logic [11:0]            idle_counter_number_th,
  input  logic [DATA_WIDTH-1:0]  channel_data,
  input  logic [COUNT_WIDTH-1:0] channel_data_counter,
  input  logic                   channel_fifo_empty,
  output logic                   channel_data_read,
  chan_eth_frame_builder_if.master tx_axis,
  output logic                   busy,
  output logic [15:0]            frame_count
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int HDR_BYTES = 18;
  localparam int HDR_W     = HDR_BYTES * 8;
  localparam int IDX_MAX   = (BYTES > HDR_BYTES) ? BYTES : HDR_BYTES;
  localparam int IDXW      = $clog2(IDX_MAX);
  localparam int CMPW      = (COUNT_WIDTH > 12) ? COUNT_WIDTH : 12;
  localparam logic [COUNT_WIDTH-1:0] MAXW = COUNT_WIDTH'(MAX_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_LOAD, ST_PAYLOAD} state_t;

  state_t                 r_state, w_state_next;
  logic [IDXW-1:0]        r_idx, w_idx_next;
  logic [HDR_W-1:0]       r_hdr, w_hdr_next;
  logic [DATA_WIDTH-1:0]  r_word, w_word_next;
  logic [COUNT_WIDTH-1:0] r_left, w_left_next;
  logic [11:0]            r_idle, w_idle_next;
  logic [15:0]            r_seq, w_seq_next;
  logic [15:0]            r_frame_count, w_frame_count_next;

  logic                   w_tvalid, w_tlast, w_read, w_accept;
  logic [7:0]             w_tdata;
  logic                   w_fill, w_timeout, w_start;
  logic [COUNT_WIDTH-1:0] w_n;
  logic [15:0]            w_n16;
  logic [CMPW-1:0]        w_th_eff;

  // Trigger evaluation; counter_th of 0 behaves as 1 so an empty FIFO never fires.
  assign w_th_eff  = (counter_th == 12'd0) ? CMPW'(1) : CMPW'(counter_th);
  assign w_fill    = CMPW'(channel_data_counter) >= w_th_eff;
  assign w_timeout = (idle_counter_number_th != 12'd0) && (r_idle >= idle_counter_number_th);
  assign w_start   = enable && !channel_fifo_empty && (w_fill || w_timeout);
  assign w_n       = (channel_data_counter > MAXW) ? MAXW : channel_data_counter;
  assign w_n16     = 16'(w_n);
  assign w_accept  = w_tvalid && tx_axis.tx_axis_fifo_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_hdr         <= '0;
      r_word        <= '0;
      r_left        <= '0;
      r_idle        <= '0;
      r_seq         <= '0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_hdr         <= w_hdr_next;
      r_word        <= w_word_next;
      r_left        <= w_left_next;
      r_idle        <= w_idle_next;
      r_seq         <= w_seq_next;
      r_frame_count <= w_frame_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_hdr_next         = r_hdr;
    w_word_next        = r_word;
    w_left_next        = r_left;
    w_idle_next        = r_idle;
    w_seq_next         = r_seq;
    w_frame_count_next = r_frame_count;
    w_tvalid           = 1'b0;
    w_tlast            = 1'b0;
    w_tdata            = 8'h00;
    w_read             = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_idle_next  = '0;
          w_left_next  = w_n;
          w_idx_next   = '0;
          // Whole header is frozen here so MAC or count changes mid-frame are ignored;
          // it is then shifted out MSB first.
          w_hdr_next   = {D_MAC_add, S_MAC_add, ETHERTYPE, CHANNEL_ID, w_n16[7:0],
                          r_seq[7:0], r_seq[15:8]};
          w_state_next = ST_HEADER;
        end else if (channel_fifo_empty) begin
          w_idle_next = '0;
        end else if (r_idle != 12'hFFF) begin
          w_idle_next = r_idle + 12'd1;
        end
      end

      ST_HEADER: begin
        w_tvalid = 1'b1;
        w_tdata  = r_hdr[HDR_W-1 -: 8];
        if (w_accept) begin
          w_hdr_next = {r_hdr[HDR_W-9:0], 8'h00};
          if (r_idx == IDXW'(HDR_BYTES - 1)) begin
            w_idx_next   = '0;
            w_state_next = ST_LOAD;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end

      ST_LOAD: begin
        // FWFT head word is consumed in the same cycle the pop strobe is raised.
        if (!channel_fifo_empty) begin
          w_read       = 1'b1;
          w_word_next  = channel_data;
          w_left_next  = r_left - 1'b1;
          w_idx_next   = '0;
          w_state_next = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        w_tvalid = 1'b1;
        w_tdata  = r_word[DATA_WIDTH-1 -: 8];
        w_tlast  = (r_idx == IDXW'(BYTES - 1)) && (r_left == '0);
        if (w_accept) begin
          w_word_next = {r_word[DATA_WIDTH-9:0], 8'h00};
          if (r_idx == IDXW'(BYTES - 1)) begin
            w_idx_next = '0;
            if (r_left != '0) begin
              w_state_next = ST_LOAD;
            end else begin
              w_state_next       = ST_IDLE;
              w_seq_next         = r_seq + 16'd1;
              w_frame_count_next = r_frame_count + 16'd1;
            end
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  assign tx_axis.tx_axis_fifo_tdata  = w_tdata;
  assign tx_axis.tx_axis_fifo_tvalid = w_tvalid;
  assign tx_axis.tx_axis_fifo_tlast  = w_tlast;
  assign channel_data_read           = w_read;
  assign busy                        = (r_state != ST_IDLE);
  assign frame_count                 = r_frame_count;
endmodule

// File: tb/tb_chan_eth_frame_builder.sv
module tb_chan_eth_frame_builder;
  localparam int DW = 120;
  localparam int CW = 10;
  localparam logic [47:0] DMAC = 48'h01_02_03_04_05_06;
  localparam logic [47:0] SMAC = 48'h0A_0B_0C_0D_0E_0F;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [11:0]    counter_th = 12'd0;
  logic [11:0]    idle_th = 12'd0;
  logic [DW-1:0]  channel_data;
  logic [CW-1:0]  channel_data_counter;
  logic           channel_fifo_empty;
  logic           channel_data_read;
  logic           busy;
  logic [15:0]    frame_count;

  chan_eth_frame_builder_if axis();

  always #5 clk = ~clk;

  chan_eth_frame_builder dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .D_MAC_add              (DMAC),
    .S_MAC_add              (SMAC),
    .counter_th             (counter_th),
    .idle_counter_number_th (idle_th),
    .channel_data           (channel_data),
    .channel_data_counter   (channel_data_counter),
    .channel_fifo_empty     (channel_fifo_empty),
    .channel_data_read      (channel_data_read),
    .tx_axis                (axis),
    .busy                   (busy),
    .frame_count            (frame_count)
  );

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] fifo_q[$];   // channel FIFO model contents
  logic [DW-1:0] gold[$];     // every word pushed since the last clearing reset
  int            gidx = 0;    // next gold word expected in a frame
  logic [8:0]    exp_q[$];    // scoreboard: {tlast, byte}
  int            read_count = 0;
  bit            pop_pending = 0;
  bit            rand_ready = 0;

  task automatic update_fifo();
    channel_fifo_empty   = (fifo_q.size() == 0);
    channel_data_counter = CW'(fifo_q.size());
    channel_data         = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  function automatic logic [DW-1:0] make_word(input int idx);
    logic [DW-1:0] w;
    for (int b = 0; b < 15; b++) w[DW-1-8*b -: 8] = 8'(idx + b * 17 + 3);
    return w;
  endfunction

  task automatic push_words(input int k);
    logic [DW-1:0] w;
    for (int i = 0; i < k; i++) begin
      w = make_word(gold.size());
      gold.push_back(w);
      fifo_q.push_back(w);
    end
    update_fifo();
  endtask

  // Header: dst MAC, src MAC, 88 B5, channel 00, N, seq LSB, seq MSB; then payload MSB first.
  task automatic expect_frame(input int n, input logic [15:0] seq);
    logic [143:0]  h;
    logic [DW-1:0] d;
    h = {DMAC, SMAC, 16'h88B5, 8'h00, 8'(n), seq[7:0], seq[15:8]};
    for (int i = 0; i < 18; i++) exp_q.push_back({1'b0, h[143-8*i -: 8]});
    for (int w = 0; w < n; w++) begin
      d = gold[gidx];
      gidx++;
      for (int b = 0; b < 15; b++)
        exp_q.push_back({(w == n - 1 && b == 14) ? 1'b1 : 1'b0, d[DW-1-8*b -: 8]});
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    compared++;
    if (got !== need) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, need);
    end
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget);
    int n = 0;
    while (frame_count !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_count", 32'(frame_count), 32'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    gold.delete();
    gidx = 0;
    pop_pending = 0;
    update_fifo();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    read_count = 0;
  endtask

  // MAC-side ready: changed just after each rising edge.
  initial begin
    axis.tx_axis_fifo_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis.tx_axis_fifo_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Channel FIFO model: a pop observed in one cycle is applied half a cycle
  // later so the head word stays stable across the edge that latches it.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pending = channel_data_read;
      if (channel_data_read) read_count++;
      update_fifo();
    end
  end

  // Monitor: pops the scoreboard on every accepted byte; checks hold during stalls.
  initial begin
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall;
    logic [8:0] e;
    int         nbytes;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    nbytes     = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
        nbytes     = 0;
      end else begin
        if (prev_stall) begin
          compared++;
          if (!axis.tx_axis_fifo_tvalid || axis.tx_axis_fifo_tdata !== prev_data ||
              axis.tx_axis_fifo_tlast !== prev_last) begin
            mismatched++;
            $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                     axis.tx_axis_fifo_tvalid, axis.tx_axis_fifo_tdata,
                     axis.tx_axis_fifo_tlast, prev_data, prev_last);
          end
        end
        if (axis.tx_axis_fifo_tvalid && axis.tx_axis_fifo_tready) begin
          compared++;
          nbytes++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_byte: got d=%02h l=%0b, required no byte",
                     axis.tx_axis_fifo_tdata, axis.tx_axis_fifo_tlast);
          end else begin
            e = exp_q.pop_front();
            if ({axis.tx_axis_fifo_tlast, axis.tx_axis_fifo_tdata} !== e) begin
              mismatched++;
              $display("FAIL byte_%0d: got d=%02h l=%0b, required d=%02h l=%0b", nbytes,
                       axis.tx_axis_fifo_tdata, axis.tx_axis_fifo_tlast, e[7:0], e[8]);
            end
          end
          if (axis.tx_axis_fifo_tlast) begin
            $display("frame accepted: %0d bytes", nbytes);
            nbytes = 0;
          end
        end
        prev_stall = axis.tx_axis_fifo_tvalid && !axis.tx_axis_fifo_tready;
        prev_data  = axis.tx_axis_fifo_tdata;
        prev_last  = axis.tx_axis_fifo_tlast;
      end
    end
  end

  initial begin
    int n;
    int viol;
    update_fifo();
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(axis.tx_axis_fifo_tvalid), 0);
    check("rst_tlast", 32'(axis.tx_axis_fifo_tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_read", 32'(channel_data_read), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    reset = 1'b0;

    // Fill trigger: 4 words, threshold 4.
    counter_th = 12'd4;
    enable     = 1'b1;
    read_count = 0;
    repeat (3) begin
      @(negedge clk);
      push_words(1);
    end
    @(negedge clk);
    check("t1_busy_below_th", 32'(busy), 0);
    push_words(1);
    expect_frame(4, 16'd0);
    @(negedge clk);
    check("t1_busy_at_start", 32'(busy), 1);
    wait_frames(16'd1, 500);
    check("t1_reads", 32'(read_count), 4);
    check("t1_scoreboard_empty", 32'(exp_q.size()), 0);
    check("t1_busy_after", 32'(busy), 0);

    // Idle timeout: 1 word, threshold 100, timeout 50.
    do_reset();
    counter_th = 12'd100;
    idle_th    = 12'd50;
    @(negedge clk);
    push_words(1);
    expect_frame(1, 16'd0);
    repeat (50) @(negedge clk);
    check("t2_busy_before_timeout", 32'(busy), 0);
    @(negedge clk);
    check("t2_busy_at_timeout", 32'(busy), 1);
    wait_frames(16'd1, 300);
    check("t2_scoreboard_empty", 32'(exp_q.size()), 0);

    // 200 words queued: 96 + 96 back to back, last 8 via timeout.
    do_reset();
    counter_th = 12'd10;
    idle_th    = 12'd20;
    enable     = 1'b0;
    @(negedge clk);
    push_words(200);
    expect_frame(96, 16'd0);
    expect_frame(96, 16'd1);
    expect_frame(8, 16'd2);
    enable = 1'b1;
    wait_frames(16'd3, 6000);
    check("t3_reads", 32'(read_count), 200);
    check("t3_scoreboard_empty", 32'(exp_q.size()), 0);

    // Random backpressure on the T1 stimulus.
    do_reset();
    counter_th = 12'd4;
    idle_th    = 12'd0;
    rand_ready = 1;
    @(negedge clk);
    push_words(4);
    expect_frame(4, 16'd0);
    wait_frames(16'd1, 1000);
    rand_ready = 0;
    check("t4_reads", 32'(read_count), 4);
    check("t4_scoreboard_empty", 32'(exp_q.size()), 0);

    // Reset during the payload of word 2, then a fresh frame for the rest.
    do_reset();
    counter_th = 12'd4;
    @(negedge clk);
    push_words(4);
    expect_frame(4, 16'd0);
    n = 0;
    while (read_count < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_second_read", 32'(read_count), 2);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_tvalid", 32'(axis.tx_axis_fifo_tvalid), 0);
    check("t5_rst_tlast", 32'(axis.tx_axis_fifo_tlast), 0);
    check("t5_rst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("t5_fifo_left", 32'(fifo_q.size()), 2);
    counter_th = 12'd2;
    gidx = 2;
    expect_frame(2, 16'd0);
    reset = 1'b0;
    wait_frames(16'd1, 500);
    check("t5_scoreboard_empty", 32'(exp_q.size()), 0);
    check("t5_fifo_drained", 32'(fifo_q.size()), 0);

    // enable gating with a full FIFO.
    do_reset();
    counter_th = 12'd4;
    enable     = 1'b0;
    @(negedge clk);
    push_words(20);
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (axis.tx_axis_fifo_tvalid || channel_data_read || busy) viol++;
    end
    check("t6_disabled_activity", 32'(viol), 0);
    check("t6_disabled_reads", 32'(read_count), 0);
    expect_frame(20, 16'd0);
    enable = 1'b1;
    @(negedge clk);
    check("t6_busy_on_enable", 32'(busy), 1);
    wait_frames(16'd1, 1000);
    check("t6_reads", 32'(read_count), 20);
    check("t6_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
